// File: rtl/alu8_seq.sv
// Sequential 8-bit ALU that time-multiplexes an external combinational 4-bit ALU
// over a low-nibble pass and a high-nibble pass, with valid/ready request and response channels.
`timescale 1ns/1ps
module alu8_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_c,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_overflow,
    output logic       rsp_zero,
    output logic       rsp_size
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] result_q, result_d;
    logic       carryLo_q, carryLo_d;
    logic       carry_q, carry_d;
    logic       overflow_q, overflow_d;
    logic       zero_q, zero_d;
    logic       size_q, size_d;

    logic       isArith;
    logic       inPass;
    logic [3:0] nibA;
    logic [3:0] nibB;
    logic [7:0] fullResult;

    assign isArith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_LT) || (op_q == OP_EQ);
    assign inPass     = (state_q == LO) || (state_q == HI);
    assign nibA       = (state_q == HI) ? a_q[7:4] : a_q[3:0];
    assign nibB       = (state_q == HI) ? b_q[7:4] : b_q[3:0];
    assign fullResult = {alu_result, result_q[3:0]};

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = LO;
                end
            end
            LO:   state_d = HI;
            HI:   state_d = DONE;
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtraction-style ops reuse the adder as a + ~b + 1; the HI pass chains the LO carry.
    always_comb begin
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_c   = ALU_ADD;
        alu_cin = 1'b0;
        if (inPass) begin
            alu_a = nibA;
            case (op_q)
                OP_ADD: begin
                    alu_b   = nibB;
                    alu_cin = (state_q == HI) ? carryLo_q : 1'b0;
                end
                OP_SUB, OP_LT, OP_EQ: begin
                    alu_b   = ~nibB;
                    alu_cin = (state_q == HI) ? carryLo_q : 1'b1;
                end
                OP_NOT: alu_c = ALU_NOT;
                OP_AND: begin
                    alu_c = ALU_AND;
                    alu_b = nibB;
                end
                OP_OR: begin
                    alu_c = ALU_OR;
                    alu_b = nibB;
                end
                OP_XOR: begin
                    alu_c = ALU_XOR;
                    alu_b = nibB;
                end
                default: alu_c = ALU_ADD;
            endcase
        end
    end

    // Response flags are registered at the HI capture so they stay put until the next operation.
    always_comb begin
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        carryLo_d  = carryLo_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        size_d     = size_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                end
            end
            LO: begin
                result_d[3:0] = alu_result;
                carryLo_d     = alu_carry;
            end
            HI: begin
                result_d[7:4] = alu_result;
                carry_d       = isArith ? alu_carry : 1'b0;
                overflow_d    = isArith ? alu_overflow : 1'b0;
                zero_d        = (fullResult == 8'h00);
                if (op_q == OP_LT) begin
                    size_d = alu_result[3] ^ alu_overflow;
                end else if (op_q == OP_EQ) begin
                    size_d = (fullResult == 8'h00);
                end else begin
                    size_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 3'b000;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            result_q   <= 8'h00;
            carryLo_q  <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            size_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            carryLo_q  <= carryLo_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            size_q     <= size_d;
        end
    end

    assign rsp_result   = result_q;
    assign rsp_carry    = carry_q;
    assign rsp_overflow = overflow_q;
    assign rsp_zero     = zero_q;
    assign rsp_size     = size_q;

endmodule

// File: tb/tb_alu8_seq.sv
// Scoreboard bench for alu8_seq: supplies the external 4-bit ALU, issues directed and random
// requests, and checks each response against an 8-bit arithmetic reference model.
`timescale 1ns/1ps
module tb_alu8_seq;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_c;
    logic       alu_cin;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_overflow;
    logic       rsp_zero;
    logic       rsp_size;

    int   nChecks = 0;
    int   nErrors = 0;
    exp_t expQ[$];

    alu8_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_size(rsp_size)
    );

    always #5 clk = ~clk;

    // The shared 4-bit ALU that the DUT borrows for each nibble pass.
    logic [4:0] aluSum;
    always_comb begin
        aluSum       = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cin};
        alu_result   = 4'h0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_c)
            3'b000: begin
                alu_result   = aluSum[3:0];
                alu_carry    = aluSum[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (aluSum[3] != alu_a[3]);
            end
            3'b010: alu_result = ~alu_a;
            3'b011: alu_result = alu_a & alu_b;
            3'b100: alu_result = alu_a | alu_b;
            3'b101: alu_result = alu_a ^ alu_b;
            default: alu_result = 4'h0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t refModel(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ua = a;
        int   ub = b;
        int   sa = $signed(a);
        int   sb = $signed(b);
        int   r  = 0;
        e = '{default: 0};
        case (op)
            3'd0: begin
                r   = ua + ub;
                e.c = (r > 255);
                e.v = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd1, 3'd6, 3'd7: begin
                r   = ua - ub + 256;
                e.c = (ua >= ub);
                e.v = (sa - sb > 127) || (sa - sb < -128);
            end
            3'd2: r = ~ua;
            3'd3: r = ua & ub;
            3'd4: r = ua | ub;
            default: r = ua ^ ub;
        endcase
        e.res = 8'(r & 255);
        e.z   = (e.res == 8'h00);
        if (op == 3'd6) e.s = (sa < sb);
        if (op == 3'd7) e.s = (ua == ub);
        return e;
    endfunction

    // Expected drive of the borrowed ALU during the LO (hi=0) or HI (hi=1) pass.
    task automatic checkAluDrive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit hi);
        logic [7:0] aw = a;
        logic [7:0] bw = b;
        int  la = aw[3:0];
        int  lb = bw[3:0];
        int  expA = hi ? aw[7:4] : aw[3:0];
        int  expB = hi ? bw[7:4] : bw[3:0];
        bit  arith = (op == 3'd0) || (op == 3'd1) || (op == 3'd6) || (op == 3'd7);
        int  expC = arith ? 0 : op;
        int  expCin = 0;
        if (op != 3'd0 && arith) expB = 15 - expB;
        if (op == 3'd2) expB = 0;
        if (arith && op != 3'd0) expCin = hi ? ((la + (15 - lb) + 1) > 15) : 1;
        if (op == 3'd0 && hi) expCin = (la + lb) > 15;
        checkOutput(hi ? "alu_a HI" : "alu_a LO", alu_a, expA);
        checkOutput(hi ? "alu_b HI" : "alu_b LO", alu_b, expB);
        checkOutput(hi ? "alu_c HI" : "alu_c LO", alu_c, expC);
        checkOutput(hi ? "alu_cin HI" : "alu_cin LO", alu_cin, expCin);
    endtask

    // Monitor: every cycle a response is presented it must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL unexpected_rsp: got valid response %0h expected none", rsp_result);
            end else begin
                checkOutput("rsp_result", rsp_result, expQ[0].res);
                checkOutput("rsp_carry", rsp_carry, expQ[0].c);
                checkOutput("rsp_overflow", rsp_overflow, expQ[0].v);
                checkOutput("rsp_zero", rsp_zero, expQ[0].z);
                checkOutput("rsp_size", rsp_size, expQ[0].s);
                if (rsp_ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int bp);
        exp_t e = refModel(op, a, b);
        checkOutput("req_ready idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        expQ.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        checkOutput("req_ready LO", req_ready, 0);
        checkOutput("rsp_valid LO", rsp_valid, 0);
        checkAluDrive(op, a, b, 1'b0);
        @(posedge clk); #1;
        checkOutput("rsp_valid HI", rsp_valid, 0);
        checkAluDrive(op, a, b, 1'b1);
        @(posedge clk); #1;
        checkOutput("rsp_valid latency", rsp_valid, 1);
        checkOutput("req_ready DONE", req_ready, 0);
        checkOutput("alu_c DONE", {alu_a, alu_b, alu_c, alu_cin}, 0);
        if (bp > 0) begin
            rsp_ready = 1'b0;
            repeat (bp) begin
                req_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            checkOutput("rsp_valid held", rsp_valid, 1);
            checkOutput("req_ready held", req_ready, 0);
        end
        @(posedge clk); #1;
        checkOutput("rsp_valid after ack", rsp_valid, 0);
        checkOutput("req_ready after ack", req_ready, 1);
        checkOutput("rsp_result retained", rsp_result, e.res);
    endtask

    // Starts an operation and resets it during the HI pass; no response may follow.
    task automatic applyAbort(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort in HI", req_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort rsp_valid", rsp_valid, 0);
        checkOutput("abort rsp_result", rsp_result, 0);
        checkOutput("abort req_ready", req_ready, 1);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("abort no rsp", rsp_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_result", rsp_result, 0);
        checkOutput("reset flags", {rsp_carry, rsp_overflow, rsp_zero, rsp_size}, 0);
        checkOutput("reset alu drive", {alu_a, alu_b, alu_c, alu_cin}, 0);

        applyStimulus(3'd0, 8'h7F, 8'h01, 0);
        applyStimulus(3'd1, 8'h10, 8'h01, 0);
        applyStimulus(3'd6, 8'h80, 8'h01, 0);
        applyStimulus(3'd6, 8'h01, 8'h80, 0);
        applyStimulus(3'd7, 8'h5A, 8'h5A, 0);
        applyStimulus(3'd5, 8'hF0, 8'hFF, 0);
        applyStimulus(3'd2, 8'hFF, 8'h3C, 0);
        applyStimulus(3'd3, 8'hA5, 8'h0F, 1);
        applyStimulus(3'd4, 8'h00, 8'h00, 0);
        applyStimulus(3'd0, 8'hFF, 8'h01, 5);

        applyAbort(3'd0, 8'h44, 8'h22);
        applyStimulus(3'd0, 8'h01, 8'h02, 0);

        rst       = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        checkOutput("reset over handshake", req_ready, 1);
        @(posedge clk); #1;
        checkOutput("reset over handshake idle", rsp_valid, 0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom), 8'($urandom), 8'($urandom),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/alu8_seq.md
ALU8_SEQ -- requirements
Module: alu8_seq

Interface
REQ-001 SHALL have ports `clk` (in, 1, sole clock, rising edge) and `rst` (in, 1, synchronous active-high reset); all state updates on the `clk` rising edge.
REQ-002 SHALL have `req_valid` (in, 1), `req_ready` (out, 1), `req_op` (in, 3), `req_a` (in, 8), `req_b` (in, 8) as the request channel.
REQ-003 SHALL encode `req_op` as: 000 add, 001 sub, 010 not-a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-004 SHALL drive the shared 4-bit ALU through `alu_a` (out, 4), `alu_b` (out, 4), `alu_c` (out, 3), `alu_cin` (out, 1).
REQ-005 SHALL take ALU results on `alu_result` (in, 4), `alu_carry` (in, 1), `alu_overflow` (in, 1); the ALU is combinational, with result valid in the same cycle.
REQ-006 SHALL have `rsp_valid` (out, 1), `rsp_ready` (in, 1), `rsp_result` (out, 8), `rsp_carry`, `rsp_overflow`, `rsp_zero`, `rsp_size` (out, 1 each) as the response channel.

Function
REQ-007 SHALL be a 4-state FSM: IDLE -> LO -> HI -> DONE -> IDLE.
REQ-008 IDLE: `req_ready`=1. A handshake occurs on `req_valid` & `req_ready`; it latches op, a and b, then moves to LO. With no request, it stays in IDLE.
REQ-009 `req_ready` SHALL be 0 in LO, HI and DONE; `req_*` changes outside IDLE have no effect.
REQ-010 LO: drive nibbles [3:0]. Capture `alu_result` into result[3:0] and `alu_carry` into an internal carry register. Move to HI unconditionally.
REQ-011 HI: drive nibbles [7:4]. Capture result[7:4], `alu_carry` and `alu_overflow`. Move to DONE unconditionally.
REQ-012 For add: `alu_c`=000 and `alu_b`=b nibble. `alu_cin` = 0 in LO and the stored carry in HI.
REQ-013 For sub, lt and eq: `alu_c`=000 and `alu_b`=~b nibble. `alu_cin` = 1 in LO and the stored carry in HI; this computes a+~b+1.
REQ-014 For not/and/or/xor: `alu_c` = 010/011/100/101 respectively, with `alu_cin`=0. For not, `alu_b`=0.
REQ-015 In IDLE and DONE, `alu_a`, `alu_b`, `alu_c` and `alu_cin` SHALL be 0.
REQ-016 `rsp_carry` SHALL be the HI-pass carry for add/sub/lt/eq; for sub, 1 means no borrow. It SHALL be 0 for logic ops.
REQ-017 `rsp_overflow` SHALL be the HI-pass overflow for add/sub/lt/eq, and 0 for logic ops.
REQ-018 `rsp_zero` SHALL be 1 iff `rsp_result`==8'h00, for every op.
REQ-019 `rsp_size` SHALL depend on the op:
- lt: result[7] XOR overflow (1 iff signed a<b).
- eq: 1 iff `rsp_result`==0.
- all other ops: 0.
REQ-020 For lt and eq, `rsp_result` SHALL be the difference a-b (mod 256).
REQ-021 DONE: `rsp_valid`=1, and all `rsp_*` outputs SHALL be held stable. The block moves to IDLE on the edge where `rsp_ready`=1; otherwise it stays in DONE.
REQ-022 `rsp_valid` SHALL be 0 in IDLE, LO and HI.
REQ-023 Latency: with request accepted at edge E0, `rsp_valid` SHALL rise after edge E0+2. This holds for every op.
REQ-024 Minimum initiation interval SHALL be 4 cycles, with `rsp_ready` held at 1.
REQ-025 `rsp_*` data outputs SHALL retain the last result after leaving DONE, until overwritten by the next LO/HI capture.

Reset
REQ-026 `rst`=1 at a clock edge SHALL force state to IDLE. It SHALL clear the latched op/a/b, result, carry and all flags to 0.
REQ-027 After reset, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0 and all flags = 0.
REQ-028 Reset in LO, HI or DONE SHALL abort the operation with no response issued. Reset SHALL take priority over a simultaneous handshake.

Verification
REQ-029 Add 8'h7F + 8'h01 -> after 3 cycles: `rsp_result`=8'h80, carry=0, overflow=1, zero=0, size=0.
REQ-030 Sub 8'h10 - 8'h01 -> `rsp_result`=8'h0F, carry=1 (borrow crosses nibble boundary), overflow=0.
REQ-031 Operations 110 (lt) and 111 (eq):
- lt, a=8'h80, b=8'h01 -> `rsp_result`=8'h7F, overflow=1, `rsp_size`=1.
- lt, a=8'h01, b=8'h80 -> `rsp_size`=0.
- eq, a=b=8'h5A -> `rsp_result`=0, zero=1, size=1.
REQ-032 Xor 8'hF0 ^ 8'hFF -> `rsp_result`=8'h0F, carry=0, overflow=0. In the LO and HI cycles, `alu_c`=101 and `alu_cin`=0.
REQ-033 Backpressure: hold `rsp_ready`=0 for 5 cycles while in DONE. `rsp_valid` and all `rsp_*` stay constant; `req_ready`=0, and a `req_valid` pulse is ignored. IDLE is reached one edge after `rsp_ready`=1.
REQ-034 Mid-operation reset: assert `rst` in HI -> next cycle state is IDLE, `rsp_valid`=0, `rsp_result`=0. A following add 8'h01+8'h02 returns 8'h03.
